// File: rtl/calc_key_pkg.sv
// calc_key_pkg: shared encodings for the key event generator.
//   - Event kind codes carried in ev_kind.
//   - State encoding of the key event FSM.
package calc_key_pkg;

  // Event kinds written into the event FIFO.
  localparam logic [1:0] KEV_PRESS   = 2'd0;
  localparam logic [1:0] KEV_LONG    = 2'd1;
  localparam logic [1:0] KEV_REPEAT  = 2'd2;
  localparam logic [1:0] KEV_RELEASE = 2'd3;

  // Key event FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } kev_state_t;

  // Width of a counter or index able to hold 0..n-1, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ev_fifo.sv
// ev_fifo: synchronous FIFO with a registered head output.
//   clk, reset   : clock, asynchronous active-low reset
//   wr_en        : write request; accepted when not full, or when full
//                  and a read happens in the same cycle
//   wr_data      : data to write
//   rd_en        : pop the head entry (ignored while empty)
//   head_data    : registered copy of the head entry, 0 while empty
//   full, empty  : occupancy flags decoded from the entry count register
module ev_fifo
  import calc_key_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] head_r;

  logic             do_rd_s;
  logic             do_wr_s;
  logic [CW-1:0]    count_next_s;
  logic [CW-1:0]    remain_s;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [WIDTH-1:0] head_next_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign head_data = head_r;

  // Read/write qualification and next value of the registered head.
  always_comb begin
    do_rd_s       = rd_en && !empty;
    do_wr_s       = wr_en && (!full || do_rd_s);
    count_next_s  = count_r + CW'(do_wr_s) - CW'(do_rd_s);
    remain_s      = count_r - CW'(do_rd_s);
    rd_ptr_next_s = rd_ptr_r + AW'(do_rd_s);
    if (count_next_s == CW'(0)) begin
      head_next_s = {WIDTH{1'b0}};
    end else if (remain_s == CW'(0)) begin
      // Storage drains to nothing this cycle, so the incoming word becomes head.
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage, pointers, count and head register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= AW'(0);
      wr_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: turns debounced key levels into PRESS / LONG / REPEAT /
// RELEASE events for one active key at a time, queued in a small FIFO.
//   clk, reset : clock, asynchronous active-low reset
//   db         : debounced key levels, 1 = pressed
//   ev_valid   : an event is available at the FIFO head
//   ev_ready   : consumer takes the head event when ev_valid=1
//   ev_key     : key index of the head event (0 while empty)
//   ev_kind    : kind of the head event (0 while empty)
//   ev_drop    : one-cycle pulse after an event was lost to a full FIFO
module key_event_gen
  import calc_key_pkg::*;
#(
  parameter int NKEYS        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NKEYS-1:0]         db,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(NKEYS)-1:0] ev_key,
  output logic [1:0]               ev_kind,
  output logic                     ev_drop
);

  localparam int KW   = $clog2(NKEYS);
  localparam int PW   = idx_width(TICK_DIV);
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int TW   = idx_width(MAXT);
  localparam int EW   = KW + 2;

  logic [NKEYS-1:0] db_q_r;
  kev_state_t       state_r;
  logic [KW-1:0]    act_key_r;
  logic [PW-1:0]    presc_r;
  logic [TW-1:0]    tick_cnt_r;
  logic             ev_drop_r;

  logic [NKEYS-1:0] rise_s;
  logic             rise_any_s;
  logic [KW-1:0]    rise_idx_s;
  logic             tick_s;
  kev_state_t       state_next_s;
  logic [KW-1:0]    act_key_next_s;
  logic [PW-1:0]    presc_next_s;
  logic [TW-1:0]    tick_cnt_next_s;
  logic             wr_s;
  logic [1:0]       kind_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [EW-1:0]    head_s;

  assign rise_s     = db & ~db_q_r;
  assign rise_any_s = |rise_s;
  assign tick_s     = (presc_r == PW'(TICK_DIV - 1));

  // Lowest-numbered rising key wins.
  always_comb begin
    rise_idx_s = KW'(0);
    for (int i = NKEYS - 1; i >= 0; i--) begin
      rise_idx_s = rise_s[i] ? KW'(i) : rise_idx_s;
    end
  end

  // Next-state, counter and event-write logic of the key FSM.
  always_comb begin
    state_next_s    = state_r;
    act_key_next_s  = act_key_r;
    presc_next_s    = presc_r;
    tick_cnt_next_s = tick_cnt_r;
    wr_s            = 1'b0;
    kind_s          = KEV_PRESS;
    case (state_r)
      ST_IDLE: begin
        presc_next_s    = PW'(0);
        tick_cnt_next_s = TW'(0);
        if (rise_any_s) begin
          act_key_next_s = rise_idx_s;
          wr_s           = 1'b1;
          kind_s         = KEV_PRESS;
          state_next_s   = ST_HELD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (!db[act_key_r]) begin
          // Release wins over a tick landing in the same cycle.
          wr_s            = 1'b1;
          kind_s          = KEV_RELEASE;
          state_next_s    = ST_IDLE;
          presc_next_s    = PW'(0);
          tick_cnt_next_s = TW'(0);
        end else begin
          presc_next_s = tick_s ? PW'(0) : presc_r + PW'(1);
          if (tick_s) begin
            if ((state_r == ST_HELD) && (tick_cnt_r == TW'(LONG_TICKS - 1))) begin
              wr_s            = 1'b1;
              kind_s          = KEV_LONG;
              tick_cnt_next_s = TW'(0);
              state_next_s    = ST_REPEAT;
            end else if ((state_r == ST_REPEAT) &&
                         (tick_cnt_r == TW'(REPEAT_TICKS - 1))) begin
              wr_s            = 1'b1;
              kind_s          = KEV_REPEAT;
              tick_cnt_next_s = TW'(0);
            end else begin
              tick_cnt_next_s = tick_cnt_r + TW'(1);
            end
          end else begin
            tick_cnt_next_s = tick_cnt_r;
          end
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        presc_next_s    = PW'(0);
        tick_cnt_next_s = TW'(0);
      end
    endcase
  end

  // FSM, edge-detect, counter and drop-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q_r     <= {NKEYS{1'b0}};
      state_r    <= ST_IDLE;
      act_key_r  <= KW'(0);
      presc_r    <= PW'(0);
      tick_cnt_r <= TW'(0);
      ev_drop_r  <= 1'b0;
    end else begin
      db_q_r     <= db;
      state_r    <= state_next_s;
      act_key_r  <= act_key_next_s;
      presc_r    <= presc_next_s;
      tick_cnt_r <= tick_cnt_next_s;
      // A full FIFO can only take a write if the consumer pops in the same cycle.
      ev_drop_r  <= wr_s && fifo_full_s && !ev_ready;
    end
  end

  ev_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_s),
    .wr_data  ({act_key_next_s, kind_s}),
    .rd_en    (ev_ready),
    .head_data(head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign ev_valid = ~fifo_empty_s;
  assign ev_key   = head_s[EW-1:2];
  assign ev_kind  = head_s[1:0];
  assign ev_drop  = ev_drop_r;

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

  logic       clk;
  logic       reset;
  logic [4:0] db;
  logic       ev_ready;
  logic       ev_valid;
  logic [2:0] ev_key;
  logic [1:0] ev_kind;
  logic       ev_drop;

  int checks;
  int failures;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] X = 2'd3;

  typedef struct {
    logic [4:0] db;
    logic       rdy;
    logic       v;
    logic [2:0] k;
    logic [1:0] kind;
    logic       drop;
  } vec_t;

  vec_t vecs [17];

  key_event_gen #(
    .NKEYS(5), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .db(db), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key(ev_key), .ev_kind(ev_kind), .ev_drop(ev_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [4:0] d, input logic r);
    db = d;
    ev_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic ev, input logic [2:0] ek,
                     input logic [1:0] ekd, input logic ed);
    checks++;
    if ({ev_valid, ev_key, ev_kind, ev_drop} !== {ev, ek, ekd, ed}) begin
      failures++;
      $display("FAIL %s: got valid=%0b key=%0d kind=%0d drop=%0b, want valid=%0b key=%0d kind=%0d drop=%0b",
               nm, ev_valid, ev_key, ev_kind, ev_drop, ev, ek, ekd, ed);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    db = 5'b00000;
    ev_ready = 1'b1;

    // Short press on key 2, then simultaneous rises on keys 0 and 3.
    vecs[0]  = '{5'b00000, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[1]  = '{5'b00100, 1'b1, 1'b1, 3'd2, P, 1'b0};
    vecs[2]  = '{5'b00100, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[3]  = '{5'b00100, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[4]  = '{5'b00100, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[5]  = '{5'b00100, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[6]  = '{5'b00000, 1'b1, 1'b1, 3'd2, X, 1'b0};
    vecs[7]  = '{5'b00000, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[8]  = '{5'b01001, 1'b1, 1'b1, 3'd0, P, 1'b0};
    vecs[9]  = '{5'b01001, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[10] = '{5'b01000, 1'b1, 1'b1, 3'd0, X, 1'b0};
    vecs[11] = '{5'b01000, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[12] = '{5'b01000, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[13] = '{5'b00000, 1'b1, 1'b0, 3'd0, P, 1'b0};
    vecs[14] = '{5'b01000, 1'b1, 1'b1, 3'd3, P, 1'b0};
    vecs[15] = '{5'b00000, 1'b1, 1'b1, 3'd3, X, 1'b0};
    vecs[16] = '{5'b00000, 1'b1, 1'b0, 3'd0, P, 1'b0};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 1'b0, 3'd0, 2'd0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].db, vecs[i].rdy);
      chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].k, vecs[i].kind, vecs[i].drop);
    end

    // Key 1 held 30 cycles: PRESS, LONG at +12, REPEAT at +20 and +28.
    for (int k = 0; k < 30; k++) begin
      step(5'b00010, 1'b1);
      if (k == 0)                 chk($sformatf("hold1_%0d", k), 1'b1, 3'd1, P, 1'b0);
      else if (k == 12)           chk($sformatf("hold1_%0d", k), 1'b1, 3'd1, L, 1'b0);
      else if (k == 20 || k == 28) chk($sformatf("hold1_%0d", k), 1'b1, 3'd1, R, 1'b0);
      else                        chk($sformatf("hold1_%0d", k), 1'b0, 3'd0, P, 1'b0);
    end
    step(5'b00000, 1'b1);
    chk("hold1_release", 1'b1, 3'd1, X, 1'b0);
    step(5'b00000, 1'b1);
    chk("hold1_after", 1'b0, 3'd0, P, 1'b0);

    // Release coincides with the LONG tick: only RELEASE is written.
    for (int k = 0; k < 12; k++) begin
      step(5'b00100, 1'b1);
      if (k == 0) chk($sformatf("prio_%0d", k), 1'b1, 3'd2, P, 1'b0);
      else        chk($sformatf("prio_%0d", k), 1'b0, 3'd0, P, 1'b0);
    end
    step(5'b00000, 1'b1);
    chk("prio_release", 1'b1, 3'd2, X, 1'b0);
    step(5'b00000, 1'b1);
    chk("prio_after", 1'b0, 3'd0, P, 1'b0);

    // Overflow: 5 events with ev_ready=0, then drain in order.
    step(5'b00001, 1'b0); chk("ovf_w1", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b0); chk("ovf_w2", 1'b1, 3'd0, P, 1'b0);
    step(5'b00001, 1'b0); chk("ovf_w3", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b0); chk("ovf_w4", 1'b1, 3'd0, P, 1'b0);
    step(5'b00001, 1'b0); chk("ovf_drop", 1'b1, 3'd0, P, 1'b1);
    step(5'b00001, 1'b1); chk("ovf_rd2", 1'b1, 3'd0, X, 1'b0);
    step(5'b00001, 1'b1); chk("ovf_rd3", 1'b1, 3'd0, P, 1'b0);
    step(5'b00001, 1'b1); chk("ovf_rd4", 1'b1, 3'd0, X, 1'b0);
    step(5'b00001, 1'b1); chk("ovf_empty", 1'b0, 3'd0, P, 1'b0);
    step(5'b00000, 1'b1); chk("ovf_release", 1'b1, 3'd0, X, 1'b0);
    step(5'b00000, 1'b1); chk("ovf_after", 1'b0, 3'd0, P, 1'b0);

    // Full FIFO with a read on the same edge as a write: write accepted.
    step(5'b00001, 1'b0); chk("frw_w1", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b0); chk("frw_w2", 1'b1, 3'd0, P, 1'b0);
    step(5'b00001, 1'b0); chk("frw_w3", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b0); chk("frw_w4", 1'b1, 3'd0, P, 1'b0);
    step(5'b00001, 1'b1); chk("frw_rw", 1'b1, 3'd0, X, 1'b0);
    step(5'b00000, 1'b0); chk("frw_still_full", 1'b1, 3'd0, X, 1'b1);
    step(5'b00000, 1'b1); chk("frw_rd1", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b1); chk("frw_rd2", 1'b1, 3'd0, X, 1'b0);
    step(5'b00000, 1'b1); chk("frw_rd3", 1'b1, 3'd0, P, 1'b0);
    step(5'b00000, 1'b1); chk("frw_empty", 1'b0, 3'd0, P, 1'b0);

    // Reset in REPEAT with key 4 held; PRESS again on first edge after release.
    for (int k = 0; k < 13; k++) begin
      step(5'b10000, 1'b1);
      if (k == 0)       chk($sformatf("rst_%0d", k), 1'b1, 3'd4, P, 1'b0);
      else if (k == 12) chk($sformatf("rst_%0d", k), 1'b1, 3'd4, L, 1'b0);
      else              chk($sformatf("rst_%0d", k), 1'b0, 3'd0, P, 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", 1'b0, 3'd0, P, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold", 1'b0, 3'd0, P, 1'b0);
    reset = 1'b1;
    step(5'b10000, 1'b1); chk("rst_press", 1'b1, 3'd4, P, 1'b0);
    step(5'b10000, 1'b1); chk("rst_idle", 1'b0, 3'd0, P, 1'b0);
    step(5'b00000, 1'b1); chk("rst_release", 1'b1, 3'd4, X, 1'b0);
    step(5'b00000, 1'b1); chk("rst_after", 1'b0, 3'd0, P, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the debounced button levels from the per-key debouncers into discrete, timestamp-free key events for the calculator's stack/queue control FSM. It sits directly downstream of the debouncers and upstream of the command decoder. It detects press edges, long-press, auto-repeat and release on one active key at a time. Events are buffered in a small FIFO behind a valid/ready handshake.

## Interface
- NKEYS, 5, number of debounced key inputs.
- TICK_DIV, 100000, clk cycles per internal hold tick (1 ms at 100 MHz).
- LONG_TICKS, 500, ticks a key must stay held after PRESS before LONG is issued.
- REPEAT_TICKS, 100, ticks between successive REPEAT events after LONG.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two, at least 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- db  in  NKEYS  debounced key levels, synchronous to clk, 1 = pressed.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts head event when ev_valid=1.
- ev_key  out  $clog2(NKEYS)  key index of head event.
- ev_kind  out  2  event kind of head event.
- ev_drop  out  1  one-cycle pulse: an event was discarded because the FIFO was full.

## Operation
- Edge detect: db_q is a register of db, reset to 0. rise = db & ~db_q.
- FSM has three states: IDLE, HELD, REPEAT. It holds the active key index act_key.
- IDLE: if any rise bit is set, the lowest set index wins. Then: act_key := index; write PRESS; clear prescaler and tick counter; go to HELD. Simultaneous rises on other keys are ignored permanently; those keys need a fresh rise later.
- HELD: if db[act_key]=0, write RELEASE and go to IDLE. Otherwise, on a tick with tick_cnt == LONG_TICKS-1: write LONG, clear tick_cnt, go to REPEAT.
- REPEAT: if db[act_key]=0, write RELEASE and go to IDLE. Otherwise, on a tick with tick_cnt == REPEAT_TICKS-1: write REPEAT and clear tick_cnt.
- Release has priority over a coincident tick. No LONG or REPEAT is written in that cycle.
- Keys other than act_key are ignored while in HELD or REPEAT.
- Prescaler: counts 0..TICK_DIV-1 while in HELD or REPEAT. tick is asserted when it equals TICK_DIV-1, then it wraps. Both counters are held at 0 in IDLE.
- Counter widths: $clog2(TICK_DIV) and $clog2(max(LONG_TICKS, REPEAT_TICKS)). No overflow is possible.
- FIFO write: {act_key, kind}.
  - If full and ev_ready=0: the event is dropped and ev_drop pulses. The FSM still advances.
  - If full and ev_ready=1 in the same cycle: the read frees a slot, the write is accepted, and there is no drop.
- FIFO read: occurs when ev_valid && ev_ready. Events are delivered strictly in order.
- ev_key and ev_kind are don't-care while ev_valid=0; the implementation drives 0.

## Timing
- Reset values: ev_valid=0, ev_key=0, ev_kind=0, ev_drop=0, FSM=IDLE, db_q=0, counters=0, FIFO empty.
- PRESS latency: db rises before edge E0, the write happens at E0, and ev_valid=1 after E0 (1 cycle).
- LONG is written at edge E0 + LONG_TICKS*TICK_DIV, assuming the key is held throughout.
- REPEAT events are written every REPEAT_TICKS*TICK_DIV cycles after LONG.
- RELEASE is written at the first edge that samples db[act_key]=0.
- Reset mid-operation clears all state immediately. Because db_q resets to 0, a key still held at reset release generates PRESS on the first clock edge after reset deassertion.
- ev_drop is registered and asserts in the cycle after the dropped write.

## Structure
- Package calc_key_pkg holds the kind encoding: KEV_PRESS=2'd0, KEV_LONG=2'd1, KEV_REPEAT=2'd2, KEV_RELEASE=2'd3. It also holds the FSM state encoding for IDLE, HELD and REPEAT.
- Sub-module ev_fifo: synchronous FIFO with parameterised width and depth, full/empty flags, and registered head output. Same reset as the parent.
- The FSM, edge detect and counters stay in key_event_gen.

## Test plan
All scenarios use NKEYS=5, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, FIFO_DEPTH=4, ev_ready=1 unless stated.
- db[2] held for 5 cycles, then released -> PRESS(key 2) valid 1 cycle after the rise, then RELEASE(key 2). No LONG.
- db[1] held for 30 cycles from edge E0 -> PRESS at E0, LONG at E0+12, REPEAT at E0+20 and E0+28, then RELEASE on drop.
- db[0] and db[3] rise on the same edge; db[0] drops while db[3] stays high -> PRESS(0), RELEASE(0), and no event for key 3 until it falls and re-rises.
- ev_ready=0 while 5 events are produced -> 4 stored, ev_drop pulses once. Setting ev_ready=1 then drains the 4 events in order.
- FIFO full with ev_ready=1 on the same edge as a new write -> no drop, and occupancy stays 4.
- Reset asserted mid-REPEAT with db[4] held -> all outputs 0 immediately. After reset deassertion: PRESS(key 4) on the first edge.
